// File: rtl/demodulate_pkg.sv
// Shared widths, fixed-point helpers, qarctan constants and FSM states for the
// FM discriminator.
package demodulate_pkg;

   localparam int DATA_SIZE   = 32;
   localparam int DATA_SIZE_2 = 2 * DATA_SIZE;
   localparam int BITS        = 10;

   localparam logic signed [DATA_SIZE-1:0] QUAD1 = 804;
   localparam logic signed [DATA_SIZE-1:0] QUAD3 = 2412;
   localparam logic signed [DATA_SIZE-1:0] GAIN  = 758;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PROD,
      S_DIV_START,
      S_DIV,
      S_ANGLE,
      S_WRITE
   } state_t;

   function automatic logic signed [DATA_SIZE-1:0] quantize(input logic signed [DATA_SIZE-1:0] v);
      return v <<< BITS;
   endfunction

   // Division by 2^BITS truncating toward zero: negative values get a bias so
   // the arithmetic shift does not round them toward minus infinity.
   function automatic logic signed [DATA_SIZE-1:0] dequantize(input logic signed [DATA_SIZE_2-1:0] v);
      logic signed [DATA_SIZE_2-1:0] bias;
      bias = '0;
      if (v < 0) bias = DATA_SIZE_2'((1 << BITS) - 1);
      return DATA_SIZE'((v + bias) >>> BITS);
   endfunction

endpackage

// File: rtl/demodulate_div.sv
// Sequential restoring signed divider: one quotient bit per cycle on magnitudes,
// sign applied on the final step; done pulses DATA_SIZE cycles after start.
module demodulate_div
   import demodulate_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_SIZE-1:0] dividend,
   input  logic [DATA_SIZE-1:0] divisor,
   output logic [DATA_SIZE-1:0] quotient,
   output logic                 done
);

   localparam int CNT_W = $clog2(DATA_SIZE);

   typedef struct packed {
      logic [DATA_SIZE-1:0] rem;
      logic [DATA_SIZE-1:0] quo;
   } step_t;

   logic                 busy;
   logic [CNT_W-1:0]     count;
   logic [DATA_SIZE-1:0] rem;
   logic [DATA_SIZE-1:0] quo;
   logic [DATA_SIZE-1:0] dvs;
   logic                 neg;
   step_t                step;

   function automatic logic [DATA_SIZE-1:0] mag(input logic [DATA_SIZE-1:0] v);
      return v[DATA_SIZE-1] ? -v : v;
   endfunction

   function automatic step_t div_step(input logic [DATA_SIZE-1:0] rem_in,
                                      input logic [DATA_SIZE-1:0] quo_in,
                                      input logic [DATA_SIZE-1:0] dvs_in);
      logic [DATA_SIZE:0] shifted;
      step_t              s;
      shifted = {rem_in, quo_in[DATA_SIZE-1]};
      s.quo   = {quo_in[DATA_SIZE-2:0], 1'b0};
      if (shifted >= {1'b0, dvs_in}) begin
         s.rem    = DATA_SIZE'(shifted - {1'b0, dvs_in});
         s.quo[0] = 1'b1;
      end else begin
         s.rem = DATA_SIZE'(shifted);
      end
      return s;
   endfunction

   // The first bit is resolved on the start edge so the last one lands in time
   // for done to be visible DATA_SIZE cycles after start.
   always_comb begin
      if (start) step = div_step('0, mag(dividend), mag(divisor));
      else       step = div_step(rem, quo, dvs);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy  <= 1'b0;
         count <= '0;
         done  <= 1'b0;
      end else begin
         done <= busy && !start && (count == CNT_W'(1));
         if (start) begin
            busy  <= 1'b1;
            count <= CNT_W'(DATA_SIZE - 1);
         end else if (busy) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (start) begin
         rem <= step.rem;
         quo <= step.quo;
         dvs <= mag(divisor);
         neg <= dividend[DATA_SIZE-1] ^ divisor[DATA_SIZE-1];
      end else if (busy) begin
         rem <= step.rem;
         quo <= step.quo;
         if (count == CNT_W'(1)) quotient <= neg ? -step.quo : step.quo;
      end
   end

endmodule

// File: rtl/demodulate.sv
// FM discriminator: pops real/imag pairs, takes the qarctan of the phase step
// against the previous sample and pushes one gain-scaled result per pair.
module demodulate
   import demodulate_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_SIZE-1:0] real_in_dout,
   input  logic                 real_in_empty,
   output logic                 real_in_rd_en,
   input  logic [DATA_SIZE-1:0] imag_in_dout,
   input  logic                 imag_in_empty,
   output logic                 imag_in_rd_en,
   output logic [DATA_SIZE-1:0] demod_out_din,
   input  logic                 demod_out_full,
   output logic                 demod_out_wr_en
);

   state_t state, next_state;

   logic signed [DATA_SIZE-1:0] real_prev, imag_prev;
   logic signed [DATA_SIZE-1:0] real_p0, imag_p0;
   logic signed [DATA_SIZE-1:0] r_p1, i_p1;
   logic signed [DATA_SIZE-1:0] demod_p2;
   logic signed [DATA_SIZE-1:0] abs_y, dividend, divisor, quotient;
   logic signed [DATA_SIZE-1:0] angle, demod_next;
   logic                        pop, div_start, div_done;

   function automatic logic signed [DATA_SIZE_2-1:0] wide_mul(input logic signed [DATA_SIZE-1:0] a,
                                                              input logic signed [DATA_SIZE-1:0] b);
      return DATA_SIZE_2'(a) * DATA_SIZE_2'(b);
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state      = state;
      pop             = 1'b0;
      div_start       = 1'b0;
      demod_out_wr_en = 1'b0;
      case (state)
         S_IDLE: begin
            if (!real_in_empty && !imag_in_empty) begin
               pop        = 1'b1;
               next_state = S_PROD;
            end
         end
         S_PROD:      next_state = S_DIV_START;
         S_DIV_START: begin
            div_start  = 1'b1;
            next_state = S_DIV;
         end
         S_DIV:       if (div_done) next_state = S_ANGLE;
         S_ANGLE:     next_state = S_WRITE;
         S_WRITE: begin
            if (!demod_out_full) begin
               demod_out_wr_en = 1'b1;
               next_state      = S_IDLE;
            end
         end
         default:     next_state = S_IDLE;
      endcase
   end

   // Pops are masked while reset is held so no FIFO entry is lost to a sample
   // that will never be processed.
   assign real_in_rd_en = pop & reset;
   assign imag_in_rd_en = pop & reset;
   assign demod_out_din = (state == S_WRITE) ? demod_p2 : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         real_prev <= '0;
         imag_prev <= '0;
      end else if (state == S_PROD) begin
         real_prev <= real_p0;
         imag_prev <= imag_p0;
      end
   end

   // ---- p0: sample latch / p1: conjugate product / p2: scaled angle ----
   always_ff @(posedge clock) begin
      if (pop) begin
         real_p0 <= real_in_dout;
         imag_p0 <= imag_in_dout;
      end
      if (state == S_PROD) begin
         r_p1 <= dequantize(wide_mul(real_prev, real_p0)) - dequantize(-wide_mul(imag_prev, imag_p0));
         i_p1 <= dequantize(wide_mul(real_prev, imag_p0)) + dequantize(-wide_mul(imag_prev, real_p0));
      end
      if (state == S_ANGLE) demod_p2 <= demod_next;
   end

   // qarctan: the +1 on |i| keeps the divisor strictly positive.
   always_comb begin
      abs_y = ((i_p1 < 0) ? -i_p1 : i_p1) + 1;
      if (r_p1 >= 0) begin
         dividend = quantize(r_p1 - abs_y);
         divisor  = r_p1 + abs_y;
      end else begin
         dividend = quantize(r_p1 + abs_y);
         divisor  = abs_y - r_p1;
      end
      angle = ((r_p1 >= 0) ? QUAD1 : QUAD3) - dequantize(wide_mul(QUAD1, quotient));
      if (i_p1 < 0) angle = -angle;
      demod_next = dequantize(wide_mul(GAIN, angle));
   end

   demodulate_div div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (divisor),
      .quotient (quotient),
      .done     (div_done)
   );

endmodule
